// File: rtl/ams_pwm_dither_pkg.sv
// Shared layout of the 24-bit DAC configuration word, used by both the AMS
// register block and the PWM dither decoder so the two cannot drift apart.
package ams_pwm_dither_pkg;

    localparam int CCW_DEF  = 24;
    localparam int DW_DEF   = 8;
    localparam int SW_DEF   = 16;

    localparam int DUTY_MSB = 23;
    localparam int DUTY_LSB = 16;
    localparam int SEQ_MSB  = 15;
    localparam int SEQ_LSB  = 0;

    typedef struct packed {
        logic [DUTY_MSB-DUTY_LSB:0] duty;
        logic [SEQ_MSB-SEQ_LSB:0]   seq;
    } dac_cfg_t;

    function automatic logic [CCW_DEF-1:0] cfg_pack(
        input logic [DUTY_MSB-DUTY_LSB:0] duty,
        input logic [SEQ_MSB-SEQ_LSB:0]   seq
    );
        dac_cfg_t c;
        c.duty   = duty;
        c.seq    = seq;
        cfg_pack = c;
    endfunction

endpackage

// File: rtl/ams_pwm_dither.sv
// Dithered PWM channel: base duty per 2^DW-cycle period plus one extra high
// cycle in periods selected by an SW-bit sequence latched once per frame.
module ams_pwm_dither
    import ams_pwm_dither_pkg::*;
#(
    parameter int CCW = CCW_DEF,
    parameter int DW  = DW_DEF,
    parameter int SW  = SW_DEF
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [CCW-1:0] cfg_i,
    output logic           pwm_o,
    output logic           period_o,
    output logic           frame_o
);

    localparam int PW = (SW > 1) ? $clog2(SW) : 1;

    logic [DW-1:0] r_cnt;
    logic [PW-1:0] r_pcnt;
    logic [DW-1:0] r_duty;
    logic [SW-1:0] r_seq;
    logic          r_pwm;
    logic          r_period;
    logic          r_frame;

    logic          w_wrap;
    logic          w_frame_end;
    logic [DW-1:0] w_cnt_nx;
    logic [PW-1:0] w_pcnt_nx;
    logic [DW-1:0] w_duty_nx;
    logic [SW-1:0] w_seq_nx;
    logic [DW:0]   w_thr_nx;
    logic [DW-1:0] w_cfg_duty;
    logic [SW-1:0] w_cfg_seq;

    // Threshold is one bit wider than the counter so duty=max plus a dither
    // bit reaches 2^DW and keeps the output high through the whole period.
    function automatic logic [DW:0] f_thr(input logic [DW-1:0] duty, input logic bit0);
        f_thr = {1'b0, duty} + {{DW{1'b0}}, bit0};
    endfunction

    assign w_cfg_duty  = cfg_i[DUTY_MSB:DUTY_LSB];
    assign w_cfg_seq   = cfg_i[SEQ_MSB:SEQ_LSB];

    assign w_wrap      = (r_cnt == {DW{1'b1}});
    assign w_frame_end = w_wrap && (r_pcnt == PW'(SW - 1));
    assign w_cnt_nx    = r_cnt + DW'(1);

    always_comb begin
        w_pcnt_nx = r_pcnt;
        w_duty_nx = r_duty;
        w_seq_nx  = r_seq;
        if (w_frame_end) begin
            w_pcnt_nx = '0;
            w_duty_nx = w_cfg_duty;
            w_seq_nx  = w_cfg_seq;
        end else if (w_wrap) begin
            w_pcnt_nx = r_pcnt + PW'(1);
            w_seq_nx  = r_seq >> 1;
        end
    end

    assign w_thr_nx = f_thr(w_duty_nx, w_seq_nx[0]);

    // Outputs are derived from next-state values so each registered output
    // lines up with the counter value it describes.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cnt    <= {DW{1'b1}};
            r_pcnt   <= PW'(SW - 1);
            r_duty   <= '0;
            r_seq    <= '0;
            r_pwm    <= 1'b0;
            r_period <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nx;
            r_pcnt   <= w_pcnt_nx;
            r_duty   <= w_duty_nx;
            r_seq    <= w_seq_nx;
            r_pwm    <= ({1'b0, w_cnt_nx} < w_thr_nx);
            r_period <= (w_cnt_nx == '0);
            r_frame  <= (w_cnt_nx == '0) && (w_pcnt_nx == '0);
        end
    end

    assign pwm_o    = r_pwm;
    assign period_o = r_period;
    assign frame_o  = r_frame;

endmodule

// File: tb/tb_ams_pwm_dither.sv
// Randomized and directed bench for ams_pwm_dither against a cycle-index
// reference model of the dithered PWM waveform.
module tb_ams_pwm_dither;

    localparam int PER = 256;
    localparam int FRM = 4096;

    logic        clk_i;
    logic        rstn_i;
    logic [23:0] cfg_i;
    logic        pwm_o;
    logic        period_o;
    logic        frame_o;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    bit          started = 0;
    int          n       = -1;
    logic [23:0] cur_cfg = '0;
    logic [2:0]  exp_o;
    int          hi_acc   = 0;
    int          frame_hi = -1;
    int          prd_cnt  = 0;
    int          frm_cnt  = 0;

    ams_pwm_dither dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .cfg_i    (cfg_i),
        .pwm_o    (pwm_o),
        .period_o (period_o),
        .frame_o  (frame_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference: cycle n after reset release sits at counter n%256 of period
    // (n/256)%16; the frame's config is whatever cfg_i held on its first edge.
    always @(posedge clk_i) begin
        int cnt, p, thr;
        if (!rstn_i) begin
            started = 1;
            n       = -1;
            exp_o   = 3'b000;
        end else if (started) begin
            n++;
            if (n % FRM == 0) cur_cfg = cfg_i;
            cnt   = n % PER;
            p     = (n / PER) % 16;
            thr   = int'(cur_cfg[23:16]) + int'(cur_cfg[p]);
            exp_o = {cnt < thr, cnt == 0, (cnt == 0) && (p == 0)};
        end
        #1;
        if (started) begin
            chk("outputs{pwm,period,frame}", int'({pwm_o, period_o, frame_o}), int'(exp_o));
            if (rstn_i) begin
                if (n % FRM == 0) hi_acc = 0;
                hi_acc += int'(pwm_o);
                if (n % FRM == FRM - 1) frame_hi = hi_acc;
                prd_cnt += int'(period_o);
                frm_cnt += int'(frame_o);
            end
        end
    end

    task automatic run(input int k);
        repeat (k) @(negedge clk_i);
    endtask

    task automatic do_reset(input logic [23:0] c);
        @(negedge clk_i);
        rstn_i = 1'b0;
        cfg_i  = c;
        run(3);
        rstn_i   = 1'b1;
        prd_cnt  = 0;
        frm_cnt  = 0;
        frame_hi = -1;
    endtask

    initial begin
        rstn_i = 1'b0;
        cfg_i  = '0;

        // all-zero config: silent output, periodic strobes
        do_reset(24'h000000);
        run(FRM);
        chk("zero_frame0_hi", frame_hi, 0);
        run(FRM);
        chk("zero_frame1_hi", frame_hi, 0);
        chk("zero_frame_pulses", frm_cnt, 2);
        chk("zero_period_pulses", prd_cnt, 32);

        do_reset(24'h800000);
        run(FRM);
        chk("half_frame_hi", frame_hi, 2048);

        do_reset(24'h400001);
        run(FRM);
        chk("dither1_frame_hi", frame_hi, 1025);

        do_reset(24'hFFFFFF);
        run(FRM);
        chk("full_frame_hi", frame_hi, 4096);

        // reset mid-period while output is high
        run(100);
        chk("pre_reset_pwm", int'(pwm_o), 1);
        rstn_i = 1'b0;
        cfg_i  = 24'h800000;
        @(posedge clk_i);
        #2;
        chk("reset_edge_outputs", int'({pwm_o, period_o, frame_o}), 0);
        @(negedge clk_i);
        run(2);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #2;
        chk("release_frame_o", int'(frame_o), 1);
        chk("release_period_o", int'(period_o), 1);
        chk("release_pwm_reloaded", int'(pwm_o), 1);
        run(300);

        // config change mid-frame is deferred to the next frame
        do_reset(24'h100000);
        run(5 * PER + 10);
        cfg_i = 24'h200000;
        run(FRM - (5 * PER + 10));
        chk("deferred_old_frame_hi", frame_hi, 256);
        run(FRM);
        chk("deferred_new_frame_hi", frame_hi, 512);

        // random configs changed at random times
        for (int r = 0; r < 2; r++) begin
            do_reset(24'($urandom));
            for (int k = 0; k < 3 * FRM; k++) begin
                @(negedge clk_i);
                if ($urandom_range(63) == 0) cfg_i = 24'($urandom);
            end
        end

        run(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
